// File: rtl/approx_add_arbiter_if.sv
// rtl/approx_add_arbiter_if.sv - request/response bundle for the shared approximate adder
// Requester i packs its operands at [i*WIDTH +: WIDTH]; master = clients/consumer, slave = arbiter.
interface approx_add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_sum;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/approx_add_arbiter.sv
// rtl/approx_add_arbiter.sv - round-robin share of one approximate adder, two-stage pipeline
// Optional error monitor: define APPROX_ERR_MON_EN to build the exact adder and err_count.
module approx_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_add_arbiter_if.slave  bus,
  output logic                 busy,
  input  logic                 err_clr,
  output logic [15:0]          err_count
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH:0] CIN = {{WIDTH{1'b0}}, (APPROX_BITS > 0)};

  logic             s1_valid_q, s1_valid_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [IDW-1:0]   s2_id_q, s2_id_d;
  logic [WIDTH:0]   s2_sum_q, s2_sum_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             s2_load, can_accept, grant_any, hs;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH:0]   a_ext, b_ext, approx_sum;

  function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign s2_load    = !s2_valid_q || bus.rsp_ready;
  assign can_accept = !s1_valid_q || s2_load;

  // Walk from the farthest offset back to ptr so the nearest valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx(ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_id  = rot_idx(ptr_q, k);
      end
    end
  end

  assign hs            = grant_any && can_accept;
  assign bus.req_ready = hs ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;

  // Approximate LSBs read as zero; the upper cells always see a carry-in of one.
  assign a_ext      = {1'b0, s1_a_q};
  assign b_ext      = {1'b0, s1_b_q};
  assign approx_sum = ((a_ext >> APPROX_BITS) + (b_ext >> APPROX_BITS) + CIN) << APPROX_BITS;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_sum_d   = s2_sum_q;
    ptr_d      = ptr_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d  = s1_id_q;
        s2_sum_d = approx_sum;
      end
    end
    if (hs) begin
      s1_valid_d = 1'b1;
      s1_id_d    = grant_id;
      s1_a_d     = bus.req_a[grant_id*WIDTH +: WIDTH];
      s1_b_d     = bus.req_b[grant_id*WIDTH +: WIDTH];
      ptr_d      = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (can_accept) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_sum_q   <= '0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_sum_q   <= s2_sum_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.rsp_sum   = s2_sum_q;
  assign busy          = s1_valid_q || s2_valid_q;

`ifdef APPROX_ERR_MON_EN
  logic [WIDTH:0] exact_sum;
  logic [15:0]    err_count_q, err_count_d;

  assign exact_sum = a_ext + b_ext;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (s1_valid_q && s2_load && (approx_sum != exact_sum) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif
endmodule

// File: tb/tb_approx_add_arbiter.sv
// tb/tb_approx_add_arbiter.sv - directed self-checking bench for approx_add_arbiter
// Expected err_count values follow APPROX_ERR_MON_EN when the bench is built with it.
module tb_approx_add_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
`ifdef APPROX_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        err_clr;
  logic [15:0] err_count;
  int          checks = 0;
  int          errors = 0;

  approx_add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  approx_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .APPROX_BITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[idx*WIDTH +: WIDTH] = a;
    bus.req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    err_clr       = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.rsp_sum !== 17'h0) begin errors++; $display("FAIL reset_rsp_sum: got %h want 0", bus.rsp_sum); end
    checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %h want 0", err_count); end
  endtask

  task automatic test_adder();
    int          v_id[5] = '{0, 2, 2, 3, 1};
    logic [15:0] v_a[5]  = '{16'h0400, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000};
    logic [15:0] v_b[5]  = '{16'h0400, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000};
    logic [16:0] v_s[5]  = '{17'h00C00, 17'h1FC00, 17'h00400, 17'h01400, 17'h10400};
    logic [3:0]  exp_rdy;
    logic [15:0] exp_err;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      set_op(v_id[t], v_a[t], v_b[t]);
      exp_rdy = 4'b0001 << v_id[t];
      bus.req_valid = exp_rdy;
      @(negedge clk);
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL add_req_ready[%0d]: got %b want %b", t, bus.req_ready, exp_rdy); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_latency[%0d]: rsp_valid=%b busy=%b want 0/1", t, bus.rsp_valid, busy); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid[%0d]: got %b want 1", t, bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 2'(v_id[t])) begin errors++; $display("FAIL add_rsp_id[%0d]: got %0d want %0d", t, bus.rsp_id, v_id[t]); end
      checks++; if (bus.rsp_sum !== v_s[t]) begin errors++; $display("FAIL add_rsp_sum[%0d]: got %h want %h", t, bus.rsp_sum, v_s[t]); end
      exp_err = MON ? 16'(t + 1) : 16'h0;
      checks++; if (err_count !== exp_err) begin errors++; $display("FAIL add_err_count[%0d]: got %0d want %0d", t, err_count, exp_err); end
    end
    @(posedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_id;
    logic [16:0] exp_sum;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i) << 10, 16'h0000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (c % 4);
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
      if (c >= 2) begin
        exp_id  = 2'((c - 2) % 4);
        exp_sum = 17'((((c - 2) % 4) + 1) << 10);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id || bus.rsp_sum !== exp_sum) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: valid=%b id=%0d sum=%h want 1/%0d/%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, exp_id, exp_sum);
        end
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] ops[3] = '{16'h0400, 16'h0800, 16'h0C00};
    logic [16:0] sums[3] = '{17'h00800, 17'h00C00, 17'h01000};
    int n = 0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_op(1, ops[0], 16'h0000);
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_low[%0d]: got %b want 0000", c, bus.req_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== sums[0]) begin
          errors++;
          $display("FAIL bp_hold[%0d]: valid=%b id=%0d sum=%h want 1/1/%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, sums[0]);
        end
      end
      if (bus.req_ready[1]) n++;
      @(posedge clk); #1;
      if (n < 3) set_op(1, ops[n], 16'h0000);
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL bp_handshakes: got %0d want 2", n); end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== sums[k]) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%b id=%0d sum=%h want 1/1/%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, sums[k]);
      end
      if (bus.req_ready[1]) n++;
      @(posedge clk); #1;
      if (n >= 3) bus.req_valid = '0;
      else set_op(1, ops[n], 16'h0000);
    end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_empty: valid=%b busy=%b want 0/0", bus.rsp_valid, busy); end
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_total: got %0d want 3", n); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_op(2, 16'h7C00, 16'h7C00);
    bus.req_valid = 4'b0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 17'h0FC00 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_full: busy=%b valid=%b sum=%h ready=%b want 1/1/0fc00/0000", busy, bus.rsp_valid, bus.rsp_sum, bus.req_ready);
    end
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_flush: valid=%b busy=%b want 0/0", bus.rsp_valid, busy); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rstmid_err: got %h want 0", err_count); end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr: got %b want 0001", bus.req_ready); end
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost[%0d]: valid=%b sum=%h want no response", c, bus.rsp_valid, bus.rsp_sum); end
    end
  endtask

  task automatic test_err_monitor();
    do_reset();
    bus.rsp_ready = 1'b1;
    set_op(0, 16'h0400, 16'h0400);
    bus.req_valid = 4'b0001;
`ifdef APPROX_ERR_MON_EN
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL err_saturate: got %h want ffff", err_count); end
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL err_clr_wins: got %h want 0", err_count); end
    err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_count !== 16'h1) begin errors++; $display("FAIL err_after_clr: got %h want 1", err_count); end
`else
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL err_tied: got %h want 0", err_count); end
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL err_tied_clr: got %h want 0", err_count); end
    err_clr = 1'b0;
`endif
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_adder();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_err_monitor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
